shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Controller that sequences a WIDTH-bit parallel-to-serial / serial-to-parallel shift register for full-duplex serial transfers. It accepts a parallel word over a valid/ready handshake and shifts it out one bit per bit-period. At the same time it shifts in WIDTH bits from `ser_in` and presents the received word over a second valid/ready handshake. It sits between a parallel producer/consumer and a serial pin pair, and owns the bit counter, bit-period divider and transfer FSM.

## Interface
- `WIDTH`, 8: bits per transfer; ≥ 2.
- `DIV`, 1: clock cycles per serial bit; ≥ 1.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  WIDTH  word to transmit.
- `lsb_first`  in  1  bit order select; present only with `SHIFT_SEQ_DIR_EN`.
- `ser_out`  out  1  current transmit bit.
- `ser_in`  in  1  receive bit, sampled on bit ticks.
- `ser_en`  out  1  bit-tick strobe; high on the last cycle of each bit period.
- `busy`  out  1  high in SHIFT.
- `out_valid`  out  1  received word available.
- `out_ready`  in  1  consumer takes the word.
- `out_data`  out  WIDTH  received word.

## Operation
- FSM states: IDLE, SHIFT, DONE. Internal state: shift register `sr[WIDTH-1:0]`, bit counter (0..WIDTH), divider counter (0..DIV-1), latched order bit.
- IDLE: `in_ready`=1.
  - Accept occurs on `in_valid && in_ready`: `sr`←`in_data`, both counters←0, order bit←`lsb_first` (or 0 without the macro), then go to SHIFT.
- SHIFT:
  - `ser_out` = `sr[WIDTH-1]` for MSB-first, `sr[0]` for LSB-first.
  - The divider increments each cycle. A tick occurs when it equals DIV-1; it then wraps to 0.
  - On a tick: `ser_en`=1.
    - MSB-first: `sr`←{`sr[WIDTH-2:0]`, `ser_in`}.
    - LSB-first: `sr`←{`ser_in`, `sr[WIDTH-1:1]`}.
    - Bit counter increments.
  - On the tick that brings the bit counter to WIDTH: go to DONE.
- DONE: `out_valid`=1 and `out_data`=`sr`, held stable. On `out_ready`: go to IDLE.
  - No same-cycle accept; this costs one bubble cycle by design.
- Outside SHIFT: `ser_out`=0, `ser_en`=0. `in_valid` is ignored outside IDLE.
- Order bit is sampled only at accept. Changing `lsb_first` mid-transfer has no effect.
- `out_data` bit order: MSB-first puts the first received bit in the MSB; LSB-first puts it in the LSB.

## Timing
- Reset (`reset_L`=0, immediate, asynchronous): state IDLE, `sr`=0, counters 0.
  - Outputs: `in_ready`=0 (gated by `reset_L`), `out_valid`=0, `busy`=0, `ser_out`=0, `ser_en`=0, `out_data`=0.
  - `in_ready`=1 from the first cycle after deassertion.
- Reference point: accept at edge k.
  - Bit i is driven on `ser_out` for cycles k+1+i·DIV … k+(i+1)·DIV.
  - `ser_in` is sampled at the edge ending bit i's period.
- `out_valid` rises at cycle k+1+WIDTH·DIV. Latency from accept is WIDTH·DIV+1 cycles.
- DIV=1: `ser_en` stays high for all WIDTH cycles of SHIFT.
- Reset asserted mid-transfer: abort to IDLE and discard data; `out_valid` is never raised for that word.
- Throughput with `out_ready` held high: one word every WIDTH·DIV+2 cycles.

## Configuration
- `SHIFT_SEQ_DIR_EN` defined:
  - The `lsb_first` port exists.
  - Per-transfer bit order is selectable as described above.
- `SHIFT_SEQ_DIR_EN` undefined:
  - The `lsb_first` port is absent.
  - Order is fixed MSB-first, with no order register.
  - Timing is otherwise identical.

## Test plan
- Reset:
  - Drive `reset_L`=0 for 3 cycles mid-clock → all outputs 0 immediately.
  - Release → `in_ready`=1 next cycle.
- WIDTH=8, DIV=1, MSB-first, `ser_in` looped to `ser_out`:
  - Send 8'hA5 → `ser_out` reads 1,0,1,0,0,1,0,1.
  - `out_valid` at k+9; `out_data`=8'hA5.
- DIV=4:
  - Drive `ser_in` with 8'h3C MSB-first, changing only after each `ser_en` → `out_data`=8'h3C.
  - `ser_en` pulses exactly 8 times, spaced 4 cycles; `out_valid` at k+33.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles in DONE while `in_valid`=1 → `out_valid`/`out_data` stable, `in_ready`=0, no accept.
  - `out_ready`=1 → IDLE next cycle, then accept.
- Mid-transfer reset:
  - Assert reset after 3 ticks → IDLE, `out_valid` never rises.
  - Next transfer of 8'h5A completes correctly.
- With `SHIFT_SEQ_DIR_EN`, `lsb_first`=1, loopback, 8'h01:
  - `ser_out` reads 1,0,0,0,0,0,0,0.
  - `out_data`=8'h01.

Source files
------------

// File: rtl/shift_sequencer.sv
// Full-duplex shift sequencer: parallel word out serially on ser_out while ser_in is captured, MSB- or LSB-first.
// Latency: WIDTH*DIV+1 cycles from accept to out_valid; one word per WIDTH*DIV+2 cycles with out_ready held high.
// Backpressure: in_ready only in IDLE; DONE holds out_valid/out_data until out_ready. Macro SHIFT_SEQ_DIR_EN adds lsb_first.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef SHIFT_SEQ_DIR_EN
    input  logic             lsb_first,
`endif
    output logic             ser_out,
    input  logic             ser_in,
    output logic             ser_en,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [DW-1:0]    div_cnt;
    logic [CW-1:0]    bit_cnt;
    logic             lsb_q;
    logic             tick;

    assign tick = (state == SHIFT) && (div_cnt == DIV_LAST);

`ifdef SHIFT_SEQ_DIR_EN
    // Bit order is frozen at accept so lsb_first may change freely mid-transfer.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            lsb_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            lsb_q <= lsb_first;
        end
    end
`else
    assign lsb_q = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state   <= IDLE;
            sr      <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr      <= in_data;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        div_cnt <= '0;
                        sr      <= lsb_q ? {ser_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], ser_in};
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == CNT_LAST) begin
                            state <= DONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                DONE: begin
                    // Return to IDLE rather than accepting directly: one bubble per word.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = reset_L && (state == IDLE);
    assign busy      = (state == SHIFT);
    assign ser_en    = tick;
    assign ser_out   = (state == SHIFT) && (lsb_q ? sr[0] : sr[WIDTH-1]);
    assign out_valid = (state == DONE);
    assign out_data  = (state == DONE) ? sr : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer (WIDTH=8, DIV=4): directed transfers, backpressure, resets, random traffic.
module tb_shift_sequencer;
    localparam int WIDTH = 8;
    localparam int DIV   = 4;

    logic             clock = 1'b0;
    logic             reset_L;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
`ifdef SHIFT_SEQ_DIR_EN
    logic             lsb_first;
`endif
    logic             ser_out;
    logic             ser_in;
    logic             ser_en;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    logic             loop_mode;
    logic             pat_mode;
    logic             ser_drv;
    logic [WIDTH-1:0] pat;
    int               ptr;

    int errors = 0;
    int checks = 0;
    int edges  = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             lsb;
        int               k;
    } txn_t;
    txn_t             txq[$];
    logic [WIDTH-1:0] exp_rx;
    int               nbits;

    shift_sequencer #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SHIFT_SEQ_DIR_EN
        .lsb_first (lsb_first),
`endif
        .ser_out   (ser_out),
        .ser_in    (ser_in),
        .ser_en    (ser_en),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) edges <= edges + 1;

    always_comb begin
        ser_in = ser_drv;
        if (loop_mode) ser_in = ser_out;
        else if (pat_mode) ser_in = (ptr < WIDTH) ? pat[WIDTH-1-ptr] : 1'b0;
    end

    always @(posedge clock) if (ser_en) ptr <= ptr + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic set_order(input logic b);
`ifdef SHIFT_SEQ_DIR_EN
        lsb_first = b;
`else
        if (b) $display("note: lsb_first unavailable in this build");
`endif
    endtask

    function automatic logic cur_lsb();
`ifdef SHIFT_SEQ_DIR_EN
        return lsb_first;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: timing derived from the accept edge k, bit i occupies relative cycles i*DIV..(i+1)*DIV-1.
    always @(negedge clock) begin
        int rel;
        int bi;
        txn_t tr;
        if (reset_L) begin
            if (txq.size() == 0) begin
                chk1("in_ready_idle", in_ready, 1'b1);
                chk1("busy_idle", busy, 1'b0);
                chk1("ser_en_idle", ser_en, 1'b0);
                chk1("ser_out_idle", ser_out, 1'b0);
                chk1("out_valid_idle", out_valid, 1'b0);
                if (in_valid) begin
                    tr.data = in_data;
                    tr.lsb  = cur_lsb();
                    tr.k    = edges + 1;
                    txq.push_back(tr);
                    exp_rx = '0;
                    nbits  = 0;
                end
            end else begin
                rel = edges - txq[0].k;
                chk1("in_ready_held", in_ready, 1'b0);
                if (rel < WIDTH * DIV) begin
                    bi = rel / DIV;
                    chk1("busy_shift", busy, 1'b1);
                    chk1("out_valid_shift", out_valid, 1'b0);
                    chk1("ser_out_bit", ser_out,
                         txq[0].lsb ? txq[0].data[bi] : txq[0].data[WIDTH-1-bi]);
                    chk1("ser_en_tick", ser_en, (rel % DIV) == DIV - 1);
                    if ((rel % DIV) == DIV - 1) begin
                        if (txq[0].lsb) exp_rx[nbits] = ser_in;
                        else exp_rx[WIDTH-1-nbits] = ser_in;
                        nbits++;
                    end
                end else begin
                    chk1("busy_done", busy, 1'b0);
                    chk1("ser_en_done", ser_en, 1'b0);
                    chk1("ser_out_done", ser_out, 1'b0);
                    chk1("out_valid_done", out_valid, 1'b1);
                    chkw("out_data_done", out_data, exp_rx);
                    if (out_ready) void'(txq.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #2 reset_L = 1'b0;
        #1;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ser_out", ser_out, 1'b0);
        chk1("rst_ser_en", ser_en, 1'b0);
        chkw("rst_out_data", out_data, '0);
        txq.delete();
        repeat (3) @(posedge clock);
        #1 reset_L = 1'b1;
    endtask

    task automatic wait_accept(output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (in_ready) ok = 1;
        end
    endtask

    task automatic xfer(input logic [WIDTH-1:0] data, input logic lsb, input logic lp,
                        input logic pm, input bit stall, input logic [WIDTH-1:0] expw);
        bit ok;
        @(posedge clock);
        #1;
        in_data = data; set_order(lsb); loop_mode = lp; pat_mode = pm; ptr = 0;
        in_valid = 1'b1; out_ready = 1'b0;
        wait_accept(ok);
        if (!ok) begin timeout("accept"); return; end
        @(posedge clock);
        #1 in_valid = stall;
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clock);
            if (out_valid) ok = 1;
        end
        if (!ok) begin timeout("out_valid"); in_valid = 1'b0; return; end
        if (stall) repeat (10) @(negedge clock);
        chkw("xfer_word", out_data, expw);
        @(posedge clock);
        #1 out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clock);
        #1 out_ready = 1'b0; pat_mode = 1'b0; loop_mode = 1'b0;
    endtask

    task automatic abort_xfer(input logic [WIDTH-1:0] data);
        bit ok;
        int ticks;
        @(posedge clock);
        #1 in_data = data; set_order(1'b0); in_valid = 1'b1; out_ready = 1'b0;
        wait_accept(ok);
        if (!ok) begin timeout("abort_accept"); return; end
        @(posedge clock);
        #1 in_valid = 1'b0;
        ticks = 0;
        for (int i = 0; i < 200 && ticks < 3; i++) begin
            @(negedge clock);
            if (ser_en) ticks++;
        end
        if (ticks < 3) timeout("abort_ticks");
        do_reset();
        repeat (WIDTH * DIV + 4) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_L = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        set_order(1'b0); loop_mode = 1'b0; pat_mode = 1'b0; ser_drv = 1'b0;
        pat = 8'h3C; ptr = 0;
        repeat (3) @(posedge clock);
        #1 reset_L = 1'b1;

        do_reset();
        xfer(8'hA5, 1'b0, 1'b1, 1'b0, 0, 8'hA5);
        xfer(8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h3C);
        xfer(8'hC3, 1'b0, 1'b1, 1'b0, 1, 8'hC3);
        abort_xfer(8'hFF);
        xfer(8'h5A, 1'b0, 1'b1, 1'b0, 0, 8'h5A);
`ifdef SHIFT_SEQ_DIR_EN
        xfer(8'h01, 1'b1, 1'b1, 1'b0, 0, 8'h01);
        xfer(8'h96, 1'b1, 1'b0, 1'b1, 1, 8'h3C);
`endif

        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            ser_drv   = 1'($urandom);
            loop_mode = ($urandom_range(0, 3) == 0);
            set_order(1'($urandom));
        end

        @(posedge clock);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (WIDTH * DIV + 10) @(posedge clock);
        #1;
        chk1("drain_idle", in_ready, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
